// File: rtl/leb128_decoder_pkg.sv
// leb128_decoder_pkg: shared state encoding, byte budgets and trap code for the LEB128 immediate decoder
package leb128_decoder_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} leb_state_t;
  localparam int LEB_MAX_BYTES_32 = 5;
  localparam int LEB_MAX_BYTES_64 = 10;
  localparam logic [3:0] TRAP_MALFORMED_LEB = 4'd6;
endpackage

// File: rtl/leb128_decoder.sv
// leb128_decoder: streaming signed/unsigned LEB128 immediate decoder with malformed/overlong detection
module leb128_decoder
  import leb128_decoder_pkg::*;
#(
  parameter int MAX_BYTES = LEB_MAX_BYTES_64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic        is_64,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [63:0] result,
  output logic [3:0]  result_len,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        error,
  output logic        busy
);
  leb_state_t  state;
  logic [63:0] acc, nxt_acc, sx, ext;
  logic [6:0]  shift, nxt_shift;
  logic [3:0]  count, nxt_count, budget;
  logic        sgn, w64, fin, over, bad;
  function automatic logic range_bad(input logic s, input logic w, input logic [6:0] b);
    return w ? (s ? !(b == 7'h00 || b == 7'h7f) : |b[6:1])
             : (s ? !(b[6:3] == 4'h0 || b[6:3] == 4'hf) : |b[6:4]);
  endfunction
  always_comb begin
    nxt_acc   = acc | ({57'd0, byte_in[6:0]} << shift);
    nxt_shift = shift + 7'd7;
    nxt_count = count + 4'd1;
    budget    = w64 ? 4'(MAX_BYTES) : 4'(LEB_MAX_BYTES_32);
    fin       = !byte_in[7];
    over      = byte_in[7] && nxt_count == budget;
    bad       = over || (fin && nxt_count == budget && range_bad(sgn, w64, byte_in[6:0]));
    sx        = (sgn && byte_in[6] && nxt_shift < 7'd64) ? nxt_acc | (~64'd0 << nxt_shift) : nxt_acc;
    ext       = w64 ? sx : sgn ? {{32{sx[31]}}, sx[31:0]} : {32'd0, sx[31:0]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= '0;
      shift        <= '0;
      count        <= '0;
      sgn          <= 1'b0;
      w64          <= 1'b0;
      result       <= '0;
      result_len   <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      byte_ready   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state      <= SHIFT;
          sgn        <= is_signed;
          w64        <= is_64;
          acc        <= '0;
          shift      <= '0;
          count      <= '0;
          byte_ready <= 1'b1;
          busy       <= 1'b1;
        end
        SHIFT: if (byte_valid) begin
          acc   <= nxt_acc;
          shift <= nxt_shift;
          count <= nxt_count;
          if (fin || over) begin
            state        <= DONE;
            byte_ready   <= 1'b0;
            result_valid <= 1'b1;
            result_len   <= nxt_count;
            error        <= bad;
            result       <= bad ? 64'd0 : ext;
          end
        end
        DONE: if (result_ready) begin
          state        <= IDLE;
          result_valid <= 1'b0;
          busy         <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_leb128_decoder.sv
// tb_leb128_decoder: directed and randomized checks of leb128_decoder against an arithmetic LEB128 model
module tb_leb128_decoder;
  logic        clk = 0, reset = 1, start = 0, is_signed = 0, is_64 = 0;
  logic [7:0]  byte_in = 0;
  logic        byte_valid = 0, result_ready = 0;
  logic        byte_ready, result_valid, error, busy;
  logic [63:0] result;
  logic [3:0]  result_len;
  logic [7:0]  bq[$];
  int          vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  leb128_decoder dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .is_64(is_64),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .result(result), .result_len(result_len), .result_valid(result_valid),
    .result_ready(result_ready), .error(error), .busy(busy)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic void model(input bit s, input bit w, output int n, output logic [63:0] res, output bit err);
    logic signed [127:0] v, one, lo, hi;
    logic [7:0] b;
    int budget, wid;
    bit term;
    one = 1; v = 0; n = 0; term = 0; b = 0;
    budget = w ? 10 : 5;
    wid = w ? 64 : 32;
    for (int i = 0; i < budget && i < bq.size(); i++) begin
      b = bq[i];
      v = v + ((one * b[6:0]) << (7 * i));
      n = i + 1;
      if (!b[7]) begin term = 1; break; end
    end
    if (s && term && b[6]) v = v - (one << (7 * n));
    lo = s ? -(one << (wid - 1)) : 0;
    hi = s ? (one << (wid - 1)) : (one << wid);
    err = !term || v < lo || v >= hi;
    res = err ? 64'd0 : v[63:0];
  endfunction
  task automatic decode(input string tag, input bit s, input bit w, input int n, input int stall_at,
                        input int stall_n, input int hold, input logic [63:0] er, input logic [3:0] el, input bit ee);
    start = 1; is_signed = s; is_64 = w;
    @(posedge clk); #1;
    start = 0;
    check({tag, ":ready"}, 64'(byte_ready), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) repeat (stall_n) begin byte_valid = 0; @(posedge clk); #1; end
      byte_valid = 1; byte_in = bq[i];
      if (i == n - 1) check({tag, ":early"}, 64'(result_valid), 64'd0);
      @(posedge clk); #1;
    end
    byte_valid = 0;
    check({tag, ":valid"}, 64'(result_valid), 64'd1);
    check({tag, ":result"}, result, er);
    check({tag, ":len"}, 64'(result_len), 64'(el));
    check({tag, ":error"}, 64'(error), 64'(ee));
    check({tag, ":ready_low"}, 64'(byte_ready), 64'd0);
    start = (hold > 0);
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, ":hold_valid"}, 64'(result_valid), 64'd1);
      check({tag, ":hold_result"}, result, er);
      check({tag, ":hold_len"}, 64'(result_len), 64'(el));
    end
    result_ready = 1;
    @(posedge clk); #1;
    result_ready = 0; start = 0;
    check({tag, ":drop"}, 64'(result_valid), 64'd0);
    check({tag, ":idle"}, 64'(busy), 64'd0);
  endtask
  initial begin
    int n, budget, len, hold;
    bit s, w, ov, ee;
    logic [63:0] er;
    logic [7:0] b;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 64'd0);
    check("rst_len", 64'(result_len), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_ready", 64'(byte_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 0;
    @(posedge clk); #1;
    bq = {8'h2a};
    decode("u32_2a", 0, 0, 1, -1, 0, 0, 64'd42, 4'd1, 0);
    bq = {8'he5, 8'h8e, 8'h26};
    decode("u64_3b", 0, 1, 3, -1, 0, 0, 64'd624485, 4'd3, 0);
    decode("u64_stall", 0, 1, 3, 1, 2, 0, 64'd624485, 4'd3, 0);
    bq = {8'h7f};
    decode("s64_7f", 1, 1, 1, -1, 0, 0, 64'hffff_ffff_ffff_ffff, 4'd1, 0);
    bq = {8'h80, 8'h7f};
    decode("s64_m128", 1, 1, 2, -1, 0, 0, -64'sd128, 4'd2, 0);
    bq = {8'hff, 8'hff, 8'hff, 8'hff, 8'h0f};
    decode("u32_max", 0, 0, 5, -1, 0, 0, 64'h0000_0000_ffff_ffff, 4'd5, 0);
    bq = {8'hff, 8'hff, 8'hff, 8'hff, 8'h1f};
    decode("u32_range", 0, 0, 5, -1, 0, 0, 64'd0, 4'd5, 1);
    bq = {8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    decode("u32_overlong", 0, 0, 5, -1, 0, 0, 64'd0, 4'd5, 1);
    bq = {8'h80, 8'h80, 8'h80, 8'h80, 8'h78};
    decode("s32_min", 1, 0, 5, -1, 0, 0, 64'hffff_ffff_8000_0000, 4'd5, 0);
    bq = {8'he5, 8'h8e, 8'h26};
    decode("bp_hold", 0, 1, 3, -1, 0, 4, 64'd624485, 4'd3, 0);
    start = 1; is_signed = 0; is_64 = 1;
    @(posedge clk); #1;
    start = 0; byte_valid = 1; byte_in = 8'he5;
    @(posedge clk); #1;
    byte_in = 8'h8e;
    @(posedge clk); #1;
    byte_valid = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(result_valid), 64'd0);
    bq = {8'h2a};
    decode("after_rst", 0, 0, 1, -1, 0, 0, 64'd42, 4'd1, 0);
    for (int k = 0; k < 60; k++) begin
      s = 1'($urandom); w = 1'($urandom);
      budget = w ? 10 : 5;
      len = ($urandom_range(0, 2) == 0) ? budget : $urandom_range(1, budget);
      ov = ($urandom_range(0, 7) == 0);
      bq = {};
      for (int i = 0; i < (ov ? budget : len); i++) begin
        b = 8'($urandom);
        b[7] = ov || (i < len - 1);
        bq.push_back(b);
      end
      model(s, w, n, er, ee);
      hold = $urandom_range(0, 3);
      decode("rnd", s, w, n, $urandom_range(0, n - 1), $urandom_range(0, 2), hold, er, 4'(n), ee);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
